// File: rtl/se_pkg.sv
// Shared types and encodings for the squeeze-excitation layer sequencer.
package se_pkg;

  localparam int unsigned CH_W    = 8;
  localparam int unsigned TILE_W  = 8;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned INSTR_W = 4;

  localparam logic [CODE_W-1:0] DW_CONV     = 3'b000;
  localparam logic [CODE_W-1:0] REDUCE_CONV = 3'b001;
  localparam logic [CODE_W-1:0] EXPAND_CONV = 3'b010;
  localparam logic [CODE_W-1:0] MUL_CONV    = 3'b011;
  localparam logic [CODE_W-1:0] SE_IDLE     = 3'b111;

  localparam logic [INSTR_W-1:0] INSTR_LOAD = 4'd1;

  typedef enum logic [1:0] {PH_DW, PH_REDUCE, PH_EXPAND, PH_MUL} phase_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PHASE, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } seq_state_e;

  // Control-unit phase code for a phase register value.
  function automatic logic [CODE_W-1:0] phase_code(input phase_e p);
    case (p)
      PH_DW:     return DW_CONV;
      PH_REDUCE: return REDUCE_CONV;
      PH_EXPAND: return EXPAND_CONV;
      default:   return MUL_CONV;
    endcase
  endfunction

endpackage

// File: rtl/se_layer_sequencer_if.sv
// Host/control-unit facing signals of the SE layer sequencer.
interface se_layer_sequencer_if;
  import se_pkg::*;

  logic                start;
  logic                abort;
  logic [CH_W-1:0]     ifm_c;
  logic [CH_W-1:0]     red_c;
  logic                done_compute;
  logic                run;
  logic [INSTR_W-1:0]  instrution;
  logic [CODE_W-1:0]   current_state_SE_layer;
  logic [TILE_W-1:0]   tile;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, abort, ifm_c, red_c, done_compute,
    output run, instrution, current_state_SE_layer, tile, busy, done, err
  );

  modport slave (
    output start, abort, ifm_c, red_c, done_compute,
    input  run, instrution, current_state_SE_layer, tile, busy, done, err
  );

endinterface

// File: rtl/se_layer_sequencer_tile_count_calc.sv
// Number of TOTAL_PE-wide tiles needed to cover a channel count (ceiling divide).
module tile_count_calc
  import se_pkg::*;
#(
  parameter int unsigned TOTAL_PE = 16
) (
  input  logic [CH_W-1:0] chan,
  output logic [CH_W:0]   ntiles_c
);

  localparam int unsigned NT_W = CH_W + 1;

  // Widened by one bit so a channel count of 255 cannot wrap before the divide.
  assign ntiles_c = NT_W'((NT_W'(chan) + NT_W'(TOTAL_PE - 1)) / NT_W'(TOTAL_PE));

endmodule

// File: rtl/se_layer_sequencer.sv
// Walks DW -> REDUCE -> EXPAND -> MUL, issuing one control-unit load per output tile.
// Optional per-tile watchdog: define SE_SEQ_WATCHDOG_EN.
module se_layer_sequencer
  import se_pkg::*;
#(
  parameter int unsigned TOTAL_PE = 16
`ifdef SE_SEQ_WATCHDOG_EN
  , parameter int unsigned WDOG_CYCLES = 65535
`endif
) (
  input logic                  clk,
  input logic                  rst,
  se_layer_sequencer_if.master bus
);

  localparam int unsigned NT_W = CH_W + 1;

  seq_state_e         state, state_d;
  phase_e             phase, phase_d;
  logic [TILE_W-1:0]  tile, tile_d;
  logic               err_q, err_d;
  logic [CH_W-1:0]    ifm_q, red_q;
  logic [CH_W-1:0]    chan;
  logic [NT_W-1:0]    ntiles_c;
  logic               wdog_hit;

  assign chan = (phase == PH_REDUCE) ? red_q : ifm_q;

  tile_count_calc #(.TOTAL_PE(TOTAL_PE)) u_tile_count (
    .chan     (chan),
    .ntiles_c (ntiles_c)
  );

`ifdef SE_SEQ_WATCHDOG_EN
  logic [15:0] wdog_cnt;

  // Counts cycles spent in the current WAIT; restarts whenever WAIT is left.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wdog_cnt <= '0;
    else                        wdog_cnt <= wdog_cnt + 16'd1;
  end

  assign wdog_hit = (state == S_WAIT) && !bus.done_compute &&
                    (wdog_cnt == 16'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state;
    phase_d = phase;
    tile_d  = tile;
    err_d   = err_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PHASE;
          phase_d = PH_DW;
          tile_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_PHASE: begin
        if (ntiles_c != '0) begin
          state_d = S_ISSUE;
        end else if (phase == PH_MUL) begin
          state_d = S_DONE;
          phase_d = PH_DW;
        end else begin
          phase_d = phase_e'(2'(phase) + 2'd1);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.done_compute) begin
          state_d = S_NEXT;
        end else if (wdog_hit) begin
          state_d = S_IDLE;
          phase_d = PH_DW;
          tile_d  = '0;
          err_d   = 1'b1;
        end
      end
      S_NEXT: begin
        if ((NT_W'(tile) + NT_W'(1)) < ntiles_c) begin
          tile_d  = tile + TILE_W'(1);
          state_d = S_ISSUE;
        end else begin
          tile_d = '0;
          if (phase == PH_MUL) begin
            state_d = S_DONE;
            phase_d = PH_DW;
          end else begin
            state_d = S_PHASE;
            phase_d = phase_e'(2'(phase) + 2'd1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d = S_IDLE;
      phase_d = PH_DW;
      tile_d  = '0;
      err_d   = err_q;
    end
  end

  // State registers plus outputs decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= S_IDLE;
      phase                      <= PH_DW;
      tile                       <= '0;
      err_q                      <= 1'b0;
      ifm_q                      <= '0;
      red_q                      <= '0;
      bus.run                    <= 1'b0;
      bus.instrution             <= '0;
      bus.current_state_SE_layer <= SE_IDLE;
      bus.tile                   <= '0;
      bus.busy                   <= 1'b0;
      bus.done                   <= 1'b0;
      bus.err                    <= 1'b0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      tile  <= tile_d;
      err_q <= err_d;
      if (state == S_IDLE && bus.start && !bus.abort) begin
        ifm_q <= bus.ifm_c;
        red_q <= bus.red_c;
      end
      bus.run        <= (state_d == S_ISSUE) || (state_d == S_WAIT);
      bus.instrution <= (state_d == S_ISSUE) ? INSTR_LOAD : '0;
      bus.current_state_SE_layer <= (state_d == S_IDLE || state_d == S_DONE) ?
                                    SE_IDLE : phase_code(phase_d);
      bus.tile       <= tile_d;
      bus.busy       <= (state_d != S_IDLE);
      bus.done       <= (state_d == S_DONE);
      bus.err        <= err_d;
    end
  end

endmodule

// File: doc/se_layer_sequencer.md
# se_layer_sequencer

Top-level scheduler for one squeeze-excitation (SE) block. It walks the four SE phases in order: DW_CONV, REDUCE_CONV, EXPAND_CONV, MUL_CONV. Each phase is split into output-channel tiles of TOTAL_PE channels. For every tile the block drives the control unit's `run` / `instrution` / `current_state_SE_layer` / `tile` inputs and waits for `done_compute` before moving on. It sits between the host/CSR start logic and the layer control unit.

## Interface
- TOTAL_PE, 16, PE columns; channels processed per tile
- WDOG_CYCLES, 65535, watchdog limit in cycles per tile (used only when the watchdog is compiled in)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin an SE block; sampled only in IDLE
- abort  in  1  return to IDLE on the next edge, from any state
- ifm_c  in  8  IFM channel count; tile basis for DW, EXPAND and MUL
- red_c  in  8  reduced channel count; tile basis for REDUCE
- done_compute  in  1  end-of-tile from the PE datapath
- run  out  1  state-advance enable to the control unit
- instrution  out  4  4'd1 for exactly one cycle per tile, otherwise 0
- current_state_SE_layer  out  3  phase code: 000 DW, 001 REDUCE, 010 EXPAND, 011 MUL, 111 idle
- tile  out  8  current tile index within the phase
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the block completes
- err  out  1  watchdog flag; sticky until the next accepted start; tied to 0 when the watchdog is compiled out

## Operation
- States: IDLE, PHASE, ISSUE, WAIT, NEXT, DONE. A separate 2-bit phase register holds the current phase.
- IDLE → PHASE:
  - on `start` with `abort` low;
  - latch `ifm_c` and `red_c`;
  - phase = DW, tile = 0, err cleared.
- PHASE:
  - compute ntiles = ceil(C/TOTAL_PE) = (C + TOTAL_PE − 1) / TOTAL_PE, using a 9-bit intermediate so that C = 255 does not wrap;
  - if ntiles = 0: advance the phase (MUL → DONE), stay in PHASE;
  - otherwise → ISSUE.
- ISSUE (one cycle): `instrution` = 1, `run` = 1 → WAIT.
- WAIT:
  - `run` = 1, `instrution` = 0;
  - `done_compute` → NEXT.
- `done_compute` is ignored in every state other than WAIT.
- NEXT (`run` = 0):
  - if tile + 1 < ntiles: tile++ → ISSUE;
  - otherwise: tile = 0 and phase++ → PHASE;
  - if the phase was MUL: → DONE.
- DONE: `done` = 1 for one cycle → IDLE.
- `current_state_SE_layer` shows the phase code in PHASE, ISSUE, WAIT and NEXT. It shows 111 in IDLE and DONE.
- `start` while busy is ignored. No queueing.
- `abort` has priority over every other transition, including a simultaneous `start` or `done_compute`:
  - → IDLE, no `done` pulse;
  - phase and tile cleared; `err` unchanged.
- Changes to `ifm_c` / `red_c` after start have no effect until the next start.

## Timing
- Reset values:
  - state IDLE, phase DW, tile 0;
  - `run` 0, `instrution` 0, `current_state_SE_layer` 111, `busy` 0, `done` 0, `err` 0.
- All outputs are registered, decoded from the state/phase/tile registers.
- `start` at edge t → PHASE at t+1 → ISSUE at t+2 (first `instrution` pulse).
- `done_compute` sampled high in WAIT at edge t → NEXT at t+1 → ISSUE of the next tile at t+2.
- Per-tile overhead: 2 cycles plus compute time. Per-phase overhead: 1 extra cycle (PHASE).
- A zero-tile phase costs exactly 1 cycle in PHASE.
- `rst` mid-operation: all registers return to reset values on that edge; no `done` pulse.

## Configuration
- SE_SEQ_WATCHDOG_EN defined:
  - a 16-bit counter clears on entry to WAIT and increments each WAIT cycle;
  - when it reaches WDOG_CYCLES with `done_compute` still low: `err` ← 1, → IDLE, no `done` pulse.
- SE_SEQ_WATCHDOG_EN undefined:
  - no counter; `err` is constant 0;
  - WAIT holds indefinitely.

## Structure
- Shared package `se_pkg`:
  - phase encodings DW_CONV / REDUCE_CONV / EXPAND_CONV / MUL_CONV (3'b000–3'b011) and SE_IDLE (3'b111);
  - sequencer state enum;
  - instruction code INSTR_LOAD = 4'd1.
- One sub-module, `tile_count_calc`: combinational ceil(C/TOTAL_PE), parameterised by TOTAL_PE.
- Watchdog counter inline, guarded by the macro.

## Test plan
- ifm_c = 32, red_c = 8, TOTAL_PE = 16, `done_compute` returned 3 cycles after each ISSUE:
  - 7 `instrution` pulses, in order DW tiles 0–1, REDUCE tile 0, EXPAND 0–1, MUL 0–1;
  - one `done` pulse, then `busy` = 0.
- red_c = 0: REDUCE skipped; `current_state_SE_layer` shows 001 for exactly 1 cycle; 6 pulses total.
- ifm_c = 255: 16 tiles per phase, `tile` runs 0–15, no wrap.
- `done_compute` pulsed in IDLE and in ISSUE: ignored; `start` during WAIT: ignored; pulse count unchanged.
- `abort` in WAIT of EXPAND tile 1, together with `done_compute`:
  - IDLE next cycle, `run` = 0, `current_state_SE_layer` = 111;
  - no `done` pulse;
  - a new start begins again at DW, tile 0.
- SE_SEQ_WATCHDOG_EN defined, WDOG_CYCLES = 10, `done_compute` held low:
  - `err` = 1 and IDLE after 10 WAIT cycles;
  - the next start clears `err`.
